// File: rtl/findface_pkg.sv
// Shared types and constants for the findface window scanner.
// WIN_SCAN_OVERLAP_EN selects overlapping (stride 1) windows instead of disjoint groups.
package findface_pkg;

    typedef enum logic [1:0] {
        WSS_IDLE = 2'd0,
        WSS_LOAD = 2'd1,
        WSS_SCAN = 2'd2,
        WSS_DONE = 2'd3
    } wss_state_t;

    localparam int LANES = 4;

`ifdef WIN_SCAN_OVERLAP_EN
    localparam int STRIDE = 1;
`else
    localparam int STRIDE = 4;
`endif

endpackage

// File: rtl/bram1w4r.sv
// One-write, four-read synchronous BRAM with registered read data (1-cycle latency).
module bram1w4r #(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_SIZE   = 1024,
    localparam int AW        = $clog2(RAM_SIZE)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr1,
    input  logic [AW-1:0]         raddr2,
    input  logic [AW-1:0]         raddr3,
    input  logic [AW-1:0]         raddr4,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [DATA_WIDTH-1:0] rdata2,
    output logic [DATA_WIDTH-1:0] rdata3,
    output logic [DATA_WIDTH-1:0] rdata4
);

    logic [DATA_WIDTH-1:0] r_mem [RAM_SIZE];

    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
        rdata1 <= r_mem[raddr1];
        rdata2 <= r_mem[raddr2];
        rdata3 <= r_mem[raddr3];
        rdata4 <= r_mem[raddr4];
    end

endmodule

// File: rtl/win_scan_sched.sv
// Load/scan sequencer for bram1w4r: streams a block in, then emits 4-word beats with back-pressure.
// WIN_SCAN_OVERLAP_EN (via findface_pkg) switches to overlapping stride-1 windows.
module win_scan_sched
    import findface_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RAM_SIZE   = 1024,
    localparam int AW        = $clog2(RAM_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [AW:0]                 len,
    input  logic                        load_valid,
    input  logic [DATA_WIDTH-1:0]       load_data,
    output logic                        load_ready,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [4*DATA_WIDTH-1:0]     out_data,
    output logic [3:0]                  out_mask,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);

    wss_state_t            r_state, w_next;
    logic [AW:0]           r_len, r_wcnt;
    logic [AW+1:0]         r_nxt, r_cur, w_ip;
    logic                  r_valid, r_last;
    logic [3:0]            r_mask, w_mask;
    logic                  w_we, w_stall, w_acc, w_issue, w_last;
    logic [AW+1:0]         w_la [LANES];
    logic [AW-1:0]         w_ra [LANES];
    logic [DATA_WIDTH-1:0] w_rd [LANES];

    assign w_we    = load_valid && (r_state == WSS_LOAD);
    assign w_stall = r_valid && !out_ready;
    assign w_acc   = r_valid && out_ready;
    // Re-reading the presented beat's address keeps the BRAM output frozen during a stall.
    assign w_ip    = w_stall ? r_cur : r_nxt;
    assign w_issue = (r_state == WSS_SCAN) && !w_stall && !(w_acc && r_last);
    assign w_last  = (w_ip + (AW+2)'(LANES)) >= {1'b0, r_len};

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign w_la[k]   = w_ip + (AW+2)'(k);
        assign w_ra[k]   = (w_la[k] >= (AW+2)'(RAM_SIZE)) ? AW'(RAM_SIZE-1) : w_la[k][AW-1:0];
        assign w_mask[k] = w_la[k] < {1'b0, r_len};
        assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = r_mask[k] ? w_rd[k] : '0;
    end

    bram1w4r #(.DATA_WIDTH(DATA_WIDTH), .RAM_SIZE(RAM_SIZE)) u_bram (
        .clk    (clk),
        .we     (w_we),
        .waddr  (r_wcnt[AW-1:0]),
        .wdata  (load_data),
        .raddr1 (w_ra[0]),
        .raddr2 (w_ra[1]),
        .raddr3 (w_ra[2]),
        .raddr4 (w_ra[3]),
        .rdata1 (w_rd[0]),
        .rdata2 (w_rd[1]),
        .rdata3 (w_rd[2]),
        .rdata4 (w_rd[3])
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= WSS_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            WSS_IDLE: if (start) w_next = (len == '0) ? WSS_DONE : WSS_LOAD;
            WSS_LOAD: if (w_we && (r_wcnt == r_len - 1'b1)) w_next = WSS_SCAN;
            WSS_SCAN: if (w_acc && r_last) w_next = WSS_DONE;
            WSS_DONE: w_next = WSS_IDLE;
            default:  w_next = WSS_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len   <= '0;
            r_wcnt  <= '0;
            r_nxt   <= '0;
            r_cur   <= '0;
            r_valid <= 1'b0;
            r_mask  <= '0;
            r_last  <= 1'b0;
        end else begin
            if (r_state == WSS_IDLE && start) begin
                r_len  <= len;
                r_wcnt <= '0;
                r_nxt  <= '0;
            end
            if (w_we) r_wcnt <= r_wcnt + 1'b1;
            if (w_issue) begin
                r_valid <= 1'b1;
                r_cur   <= r_nxt;
                r_nxt   <= r_nxt + (AW+2)'(STRIDE);
                r_mask  <= w_mask;
                r_last  <= w_last;
            end else if (!w_stall) begin
                r_valid <= 1'b0;
                r_mask  <= '0;
                r_last  <= 1'b0;
            end
        end
    end

    assign load_ready = (r_state == WSS_LOAD);
    assign busy       = (r_state == WSS_LOAD) || (r_state == WSS_SCAN);
    assign done       = (r_state == WSS_DONE);
    assign out_valid  = r_valid;
    assign out_mask   = r_mask;
    assign out_last   = r_last;

endmodule

// File: tb/tb_win_scan_sched.sv
// Self-checking bench for win_scan_sched: table-driven jobs, stall/reset/zero-length sequences, random jobs.
module tb_win_scan_sched;
    import findface_pkg::*;

    localparam int DW = 32;
    localparam int RS = 1024;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst, start, load_valid, out_ready;
    logic [AW:0]     len;
    logic [DW-1:0]   load_data;
    logic            load_ready, out_valid, out_last, busy, done;
    logic [4*DW-1:0] out_data;
    logic [3:0]      out_mask;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] mem [RS];

    typedef struct {
        int         n;
        int         beats;
        logic [3:0] lmask;
    } vec_t;
    vec_t tbl [6];

    win_scan_sched #(.DATA_WIDTH(DW), .RAM_SIZE(RS)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_mask(out_mask), .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic start_job(input int n);
        @(negedge clk);
        start = 1'b1;
        len   = n[AW:0];
        @(negedge clk);
        start = 1'b0;
    endtask

    // Feeds n words; assumes the block is in LOAD. Ends at the negedge after the last write.
    task automatic load_words(input int n, input bit seq, input int base, input bit gaps);
        int w = 0;
        while (w < n) begin
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_data  = seq ? DW'(base + w) : $urandom;
            start      = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
            len        = '0;
            if (load_valid) begin
                chk("load_ready", load_ready, 1'b1);
                mem[w] = load_data;
                w++;
            end
            @(negedge clk);
        end
        load_valid = 1'b0;
        start      = 1'b0;
    endtask

    // mode 0: always ready, 1: random ready, 2: 3-cycle stall after first accepted beat.
    task automatic scan(input int n, input int mode, input int exp_beats, input logic [3:0] exp_lmask);
        int         ps[$];
        int         p = 0;
        int         idx = 0;
        int         cyc = 0;
        int         stl = 0;
        bit         got_last = 0;
        bit         prev_stall = 0;
        logic [127:0] prev_d, ed;
        logic [3:0] prev_m, em, lm;
        forever begin
            ps.push_back(p);
            if (p + LANES >= n) break;
            p += STRIDE;
        end
        chk("lat_n1_valid", out_valid, 1'b0);
        chk("lat_n1_busy", busy, 1'b1);
        out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        chk("lat_n2_valid", out_valid, 1'b1);
        while (!got_last && cyc < 8 * n + 64) begin
            if (out_valid) begin
                if (idx >= ps.size()) begin
                    chk("extra_beat", 1'b1, 1'b0);
                end else begin
                    ed = '0;
                    em = '0;
                    for (int k = 0; k < LANES; k++)
                        if (ps[idx] + k < n) begin
                            ed[k*DW +: DW] = mem[ps[idx] + k];
                            em[k] = 1'b1;
                        end
                    chk($sformatf("beat%0d_data", idx), out_data, ed);
                    chk($sformatf("beat%0d_mask", idx), out_mask, em);
                    chk($sformatf("beat%0d_last", idx), out_last, idx == ps.size() - 1);
                end
                if (prev_stall) begin
                    chk("stall_data_stable", out_data, prev_d);
                    chk("stall_mask_stable", out_mask, prev_m);
                end
            end else if (mode == 0) begin
                chk("no_bubble", out_valid, 1'b1);
            end
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    out_ready = !(idx == 1 && stl < 3);
                    if (!out_ready) stl++;
                end
            endcase
            prev_stall = out_valid && !out_ready;
            prev_d = out_data;
            prev_m = out_mask;
            if (out_valid && out_ready) begin
                idx++;
                if (out_last) begin
                    got_last = 1;
                    lm = out_mask;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (!got_last) begin
            chk("scan_timeout", 1'b0, 1'b1);
        end else begin
            chk("beat_count", idx, exp_beats);
            chk("last_mask", lm, exp_lmask);
            chk("done_pulse", done, 1'b1);
            chk("busy_fall", busy, 1'b0);
            chk("valid_after", out_valid, 1'b0);
            out_ready = 1'b0;
            @(negedge clk);
            chk("done_once", done, 1'b0);
        end
        out_ready = 1'b0;
    endtask

    task automatic full_job(input int n, input bit seq, input int base, input bit gaps,
                            input int mode, input int eb, input logic [3:0] elm);
        start_job(n);
        chk("busy_c1", busy, 1'b1);
        chk("load_ready_c1", load_ready, 1'b1);
        load_words(n, seq, base, gaps);
        scan(n, mode, eb, elm);
    endtask

    task automatic model_counts(input int n, output int eb, output logic [3:0] elm);
        int p = 0;
        eb = 1;
        while (p + LANES < n) begin
            p += STRIDE;
            eb++;
        end
        elm = '0;
        for (int k = 0; k < LANES; k++) if (p + k < n) elm[k] = 1'b1;
    endtask

    initial begin
        int         eb;
        logic [3:0] elm;
`ifdef WIN_SCAN_OVERLAP_EN
        tbl[0] = '{8, 5, 4'hF};
        tbl[1] = '{6, 3, 4'hF};
        tbl[2] = '{1, 1, 4'h1};
        tbl[3] = '{3, 1, 4'h7};
        tbl[4] = '{4, 1, 4'hF};
        tbl[5] = '{5, 2, 4'hF};
`else
        tbl[0] = '{8, 2, 4'hF};
        tbl[1] = '{6, 2, 4'h3};
        tbl[2] = '{1, 1, 4'h1};
        tbl[3] = '{4, 1, 4'hF};
        tbl[4] = '{5, 2, 4'h1};
        tbl[5] = '{13, 4, 4'h1};
`endif
        rst = 1'b1; start = 1'b0; len = '0; load_valid = 1'b0; load_data = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_load_ready", load_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, '0);
        chk("rst_out_mask", out_mask, 4'h0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            full_job(tbl[i].n, 1'b1, 32'h10, 1'b0, 0, tbl[i].beats, tbl[i].lmask);

        // Zero-length job: straight to DONE, no load, no beats.
        start_job(0);
        chk("len0_done", done, 1'b1);
        chk("len0_load_ready", load_ready, 1'b0);
        chk("len0_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("len0_done_once", done, 1'b0);
        chk("len0_valid2", out_valid, 1'b0);

        // Mid-scan stall.
        model_counts(16, eb, elm);
        full_job(16, 1'b1, 32'h100, 1'b0, 2, eb, elm);

        // Reset in the middle of LOAD.
        start_job(8);
        load_words(3, 1'b1, 32'h10, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_load_ready", load_ready, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_data", out_data, '0);
        chk("mid_rst_mask", out_mask, 4'h0);
        chk("mid_rst_last", out_last, 1'b0);
        chk("mid_rst_done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", busy, 1'b0);
        full_job(4, 1'b1, 32'h40, 1'b0, 0, 1, 4'hF);

        // Random jobs with gapped loads and random back-pressure.
        for (int j = 0; j < 6; j++) begin
            int n = $urandom_range(1, 64);
            model_counts(n, eb, elm);
            full_job(n, 1'b0, 0, 1'b1, 1, eb, elm);
        end
        model_counts(RS, eb, elm);
        full_job(RS, 1'b0, 0, 1'b1, 1, eb, elm);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
